lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised last-in-first-out stack with a show-ahead top-of-stack output, occupancy count and sticky overflow/underflow error flags. It supersedes the fixed 16-bit LIFO. Datapath blocks use it for call/return and operand stacking where width and depth differ per instance. It is single-clock, with registered status outputs and no combinational path from `push`/`pop` to any output.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `DEPTH`, 16, number of entries (≥2, need not be a power of two)
- `AF_LEVEL`, DEPTH-1, count at or above which `almost_full` asserts
- `CW`, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- `clock`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `push`  in  1  write `data` onto stack this cycle
- `pop`  in  1  remove top entry this cycle
- `clear`  in  1  synchronous flush; count to 0
- `err_clr`  in  1  synchronous clear of sticky error flags
- `data`  in  WIDTH  word to push
- `q`  out  WIDTH  current top of stack (registered; valid when `!empty`)
- `count`  out  CW  current occupancy, 0..DEPTH
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `almost_full`  out  1  count ≥ AF_LEVEL
- `overflow`  out  1  sticky; a push was rejected
- `underflow`  out  1  sticky; a pop was rejected

## Operation
- Reset (resetn=0, async): count=0, q=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0. Storage array is not reset.
- Top entry is held in the `q` register. The array holds the remaining count-1 entries, indexed 0 (bottom) to count-2.
- Per-cycle action, in priority order:
  - `clear`: count←0 and q unchanged. Push and pop are ignored and set no error flags.
  - push & !pop, count<DEPTH: array[count-1]←q if count>0; q←data; count+1.
  - push & !pop, full: no state change; overflow←1.
  - pop & !push, count>0: q←array[count-2] if count≥2, else q unchanged; count-1.
  - pop & !push, empty: no change; underflow←1.
  - push & pop, count>0: replace. q←data, count unchanged, array untouched. Legal even when full.
  - push & pop, empty: behaves as push; underflow←1.
- `err_clr` clears both sticky flags. A new error in the same cycle wins, so the flag stays 1.
- `empty`, `full` and `almost_full` are registered from next-count and always agree with `count`.
- Count arithmetic is CW bits wide and never wraps. Saturation is enforced by the reject rules above.

## Timing
- Push latency: data pushed at edge N is on `q` after edge N, in the same cycle that `count` updates.
- Pop latency: the new top is visible on `q` after the popping edge. Back-to-back pops every cycle are supported.
- Status and error flags update on the same edge as `count`.
- Reset mid-operation: outputs go to reset values immediately, without waiting for a clock edge. Operation resumes on the first edge with resetn=1.
- Array read is combinational at index count-2 and registered into `q`. Array write is synchronous.

## Structure
- Shared package `lifo_pkg`: reset-value constant for `q`, and the count-width function/constant derived from DEPTH.
- One sub-module `lifo_mem`: WIDTH×(DEPTH-1) array with one synchronous write port and one asynchronous read port. This allows later swap to a vendor RAM.
- Control, count and flag logic stay in `lifo_stack`.

## Test plan
Use WIDTH=16, DEPTH=4 unless stated.
- Reset then idle -> count=0, empty=1, full=0, q=0000, overflow=0, underflow=0.
- Push 1111, 2222, 3333, 4444 -> full=1, count=4, q=4444. Pops then return q=3333, 2222, 1111, then empty=1.
- When full, push 5555 -> overflow=1, q=4444, count=4. Then err_clr -> overflow=0.
- Push+pop with count=4 and data=AAAA -> q=AAAA, count=4, no flag. Next pop -> q=3333.
- Pop when empty -> underflow=1, count=0. Push+pop when empty with data=BBBB -> q=BBBB, count=1, underflow=1.
- clear at count=3 together with push -> count=0, empty=1, no error. Assert resetn=0 mid-burst -> all outputs take reset values without a clock edge.

Source files
------------

// File: rtl/lifo_pkg.sv
// lifo_pkg: shared constants and helpers for the lifo_stack slice
package lifo_pkg;
  localparam bit Q_RST_BIT = 1'b0;
  function automatic int lifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: WIDTH x (DEPTH-1) storage, one synchronous write port and one asynchronous read port
module lifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [0:DEPTH-2];
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH - 1; i++)
      if (we_i && waddr_i == AW'(i)) mem_q[i] <= wdata_i;
  end
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH - 1; i++)
      if (raddr_i == AW'(i)) rdata_o = mem_q[i];
  end
endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with registered show-ahead top, occupancy count and sticky error flags
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CW      = lifo_cw(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] q_q, q_d, rd_data;
  logic [CW-1:0]    count_q, count_d, waddr, raddr;
  logic             empty_q, full_q, af_q, ovf_q, ovf_d, udf_q, udf_d, we;
  // The top word lives in q_q; the array holds entries below it, so indices lag count by one
  assign waddr = count_q - CW'(1);
  assign raddr = count_q - CW'(2);
  lifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(CW)) u_mem (
    .clk_i  (clock),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(q_q),
    .raddr_i(raddr),
    .rdata_o(rd_data)
  );
  always_comb begin
    count_d = count_q;
    q_d     = q_q;
    ovf_d   = ovf_q & ~err_clr;
    udf_d   = udf_q & ~err_clr;
    we      = 1'b0;
    if (clear) count_d = '0;
    else if (push && pop) begin
      q_d = data;
      if (empty_q) begin
        count_d = CW'(1);
        udf_d   = 1'b1;
      end
    end else if (push) begin
      if (full_q) ovf_d = 1'b1;
      else begin
        we      = !empty_q;
        q_d     = data;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (empty_q) udf_d = 1'b1;
      else begin
        q_d     = (count_q >= CW'(2)) ? rd_data : q_q;
        count_d = count_q - CW'(1);
      end
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_q     <= {WIDTH{Q_RST_BIT}};
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
      full_q  <= count_d == CW'(DEPTH);
      af_q    <= count_d >= CW'(AF_LEVEL);
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  assign q           = q_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed vector table, async reset check and randomized queue-model comparison
module tb_lifo_stack;
  localparam int W = 16, D = 4, CW = 3;
  logic clock = 0, resetn = 0, push = 0, pop = 0, clear = 0, err_clr = 0;
  logic [W-1:0] data = '0, q;
  logic [CW-1:0] count;
  logic empty, full, almost_full, overflow, underflow;
  int checks = 0, errors = 0;

  lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .resetn(resetn), .push(push), .pop(pop), .clear(clear),
    .err_clr(err_clr), .data(data), .q(q), .count(count), .empty(empty),
    .full(full), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic pu, po, cl, ec;
    logic [W-1:0] d, eq;
    int ec_n;
    logic ee, ef, eaf, eo, eu;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq, input int ec,
                         input logic ee, ef, eaf, eo, eu);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".empty"}, 32'(empty), 32'(ee));
    chk({tag, ".full"}, 32'(full), 32'(ef));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(eaf));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
  endtask

  task automatic step(input logic pu, po, cl, ec, input logic [W-1:0] d);
    push = pu; pop = po; clear = cl; err_clr = ec; data = d;
    @(posedge clock); #1;
    push = 0; pop = 0; clear = 0; err_clr = 0;
  endtask

  function automatic vec_t mk(logic pu, po, cl, ec, logic [W-1:0] d, logic [W-1:0] eq,
                              int c, logic eo, eu);
    vec_t v;
    v.pu = pu; v.po = po; v.cl = cl; v.ec = ec; v.d = d; v.eq = eq; v.ec_n = c;
    v.ee = (c == 0); v.ef = (c == D); v.eaf = (c >= D - 1); v.eo = eo; v.eu = eu;
    return v;
  endfunction

  logic [W-1:0] st[$];
  logic [W-1:0] mq;
  logic mo, mu;

  initial begin
    vt.push_back(mk(0,0,0,0,16'h0000,16'h0000,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h1111,16'h1111,1,0,0));
    vt.push_back(mk(1,0,0,0,16'h2222,16'h2222,2,0,0));
    vt.push_back(mk(1,0,0,0,16'h3333,16'h3333,3,0,0));
    vt.push_back(mk(1,0,0,0,16'h4444,16'h4444,4,0,0));
    vt.push_back(mk(1,0,0,0,16'h5555,16'h4444,4,1,0));
    vt.push_back(mk(0,0,0,1,16'h0000,16'h4444,4,0,0));
    vt.push_back(mk(1,1,0,0,16'hAAAA,16'hAAAA,4,0,0));
    vt.push_back(mk(0,1,0,0,16'h0000,16'h3333,3,0,0));
    vt.push_back(mk(0,1,0,0,16'h0000,16'h2222,2,0,0));
    vt.push_back(mk(0,1,0,0,16'h0000,16'h1111,1,0,0));
    vt.push_back(mk(0,1,0,0,16'h0000,16'h1111,0,0,0));
    vt.push_back(mk(0,1,0,0,16'h0000,16'h1111,0,0,1));
    vt.push_back(mk(1,1,0,0,16'hBBBB,16'hBBBB,1,0,1));
    vt.push_back(mk(1,0,0,0,16'h0001,16'h0001,2,0,1));
    vt.push_back(mk(1,0,0,0,16'h0002,16'h0002,3,0,1));
    vt.push_back(mk(1,0,1,0,16'h9999,16'h0002,0,0,1));
    vt.push_back(mk(0,1,0,1,16'h0000,16'h0002,0,0,1));
    vt.push_back(mk(0,0,0,1,16'h0000,16'h0002,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0077,16'h0077,1,0,0));
    vt.push_back(mk(0,1,0,0,16'h0000,16'h0077,0,0,0));

    repeat (2) @(posedge clock);
    #1 resetn = 1;
    foreach (vt[i]) begin
      step(vt[i].pu, vt[i].po, vt[i].cl, vt[i].ec, vt[i].d);
      chk_all($sformatf("vec%0d", i), vt[i].eq, vt[i].ec_n, vt[i].ee, vt[i].ef,
              vt[i].eaf, vt[i].eo, vt[i].eu);
    end

    step(1,0,0,0,16'hC001);
    step(1,0,0,0,16'hC002);
    step(0,1,0,0,16'h0000);
    push = 1; data = 16'hC003;
    #3 resetn = 0;
    #1 chk_all("async_rst", 16'h0000, 0, 1, 0, 0, 0, 0);
    push = 0;
    @(posedge clock); #1 resetn = 1;
    chk_all("rst_hold", 16'h0000, 0, 1, 0, 0, 0, 0);

    st = {}; mq = '0; mo = 0; mu = 0;
    for (int n = 0; n < 600; n++) begin
      logic pu, po, cl, ec;
      logic [W-1:0] d;
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 4);
      ec = ($urandom_range(0, 99) < 10);
      d  = W'($urandom);
      if (ec) begin mo = 0; mu = 0; end
      if (cl) st = {};
      else if (pu && po) begin
        if (st.size() == 0) begin st.push_back(d); mu = 1; end
        else st[st.size() - 1] = d;
      end else if (pu) begin
        if (st.size() == D) mo = 1; else st.push_back(d);
      end else if (po) begin
        if (st.size() == 0) mu = 1; else void'(st.pop_back());
      end
      if (st.size() > 0) mq = st[st.size() - 1];
      step(pu, po, cl, ec, d);
      chk_all($sformatf("rnd%0d", n), mq, st.size(), st.size() == 0, st.size() == D,
              st.size() >= D - 1, mo, mu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
